// File: rtl/fifo_pkg.sv
// Shared constants for the thresholded FIFO: default geometry, the layout of
// the packed 8-bit threshold word and the thresholds restored by reset.
package fifo_pkg;

    localparam int DATA_WIDTH_DEF      = 6;
    localparam int ADDR_WIDTH_DEF      = 3;

    // Threshold word layout: [3:0] low threshold, [7:4] high threshold.
    localparam int UMBRAL_W            = 4;
    localparam int BAJO_LSB            = 0;
    localparam int ALTO_LSB            = 4;

    localparam int UMBRAL_BAJO_RST_DEF = 1;
    localparam int UMBRAL_ALTO_RST_DEF = (1 << ADDR_WIDTH_DEF) - 1;

    // Extract one 4-bit threshold field from the packed threshold word.
    function automatic logic [UMBRAL_W-1:0] umbral_field(input logic [7:0] word,
                                                         input int         lsb);
        return word[lsb +: UMBRAL_W];
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DATA_WIDTH register file with one synchronous write port and one
// registered read port. Only the read register is reset; storage is not.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Storage write; a same-address read in the same cycle returns the old word.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read register: loads only on an accepted read, otherwise holds.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/fifo_umbral.sv
// Synchronous FIFO with programmable low/high occupancy thresholds.
// Handshake: push and pop are requests sampled on each posedge. A push is
// accepted when the FIFO is not full, or when full and a pop is accepted in
// the same cycle; a pop is accepted only when not empty (no fall-through).
// valid_out pulses for exactly one cycle, one edge after each accepted pop,
// with data_out carrying that word; there is no downstream backpressure.
// Rejected requests set the sticky fifo_error, cleared only by reset.
module fifo_umbral
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH      = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH      = ADDR_WIDTH_DEF,
    parameter int UMBRAL_BAJO_RST = UMBRAL_BAJO_RST_DEF,
    parameter int UMBRAL_ALTO_RST = (1 << ADDR_WIDTH) - 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cfg_load,
    input  logic [7:0]            umbral,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic                  fifo_full,
    output logic                  fifo_empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  fifo_error,
    output logic [ADDR_WIDTH:0]   count
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    // Comparison width wide enough for both the count and a 4-bit threshold.
    localparam int CW    = (ADDR_WIDTH + 2 > UMBRAL_W + 1) ? ADDR_WIDTH + 2 : UMBRAL_W + 1;

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [UMBRAL_W-1:0]   umbral_bajo;
    logic [UMBRAL_W-1:0]   umbral_alto;
    logic                  push_ok;
    logic                  pop_ok;
    logic [CW-1:0]         count_w;
    logic [CW-1:0]         bajo_w;
    logic [CW-1:0]         alto_w;
    logic [CW-1:0]         alto_eff;

    // Acceptance: pop needs data present; push needs room or a same-cycle pop.
    always_comb begin
        pop_ok  = pop && !fifo_empty;
        push_ok = push && (!fifo_full || pop_ok);
    end

    // Write/read pointers, wrapping naturally modulo DEPTH.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Occupancy: unchanged when a push and a pop are both accepted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else begin
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Read-valid pulse, one cycle after each accepted pop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_out <= 1'b0;
        end else begin
            valid_out <= pop_ok;
        end
    end

    // Sticky error on any rejected push or pop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fifo_error <= 1'b0;
        end else if ((push && !push_ok) || (pop && !pop_ok)) begin
            fifo_error <= 1'b1;
        end
    end

    // Threshold capture; raw values are kept, clamping happens at compare.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            umbral_bajo <= UMBRAL_W'(UMBRAL_BAJO_RST);
            umbral_alto <= UMBRAL_W'(UMBRAL_ALTO_RST);
        end else if (cfg_load) begin
            umbral_bajo <= umbral_field(umbral, BAJO_LSB);
            umbral_alto <= umbral_field(umbral, ALTO_LSB);
        end
    end

    // Status flags from registered count and thresholds; high threshold is
    // clamped into 1..DEPTH so almost_full is always reachable and never idle-high.
    always_comb begin
        count_w  = CW'(count);
        bajo_w   = CW'(umbral_bajo);
        alto_w   = CW'(umbral_alto);
        alto_eff = alto_w;
        if (alto_w == '0) begin
            alto_eff = CW'(1);
        end else if (alto_w > CW'(DEPTH)) begin
            alto_eff = CW'(DEPTH);
        end
        fifo_full    = (count_w == CW'(DEPTH));
        fifo_empty   = (count_w == '0);
        almost_full  = (count_w >= alto_eff);
        almost_empty = (count_w <= bajo_w);
    end

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (push_ok),
        .wr_addr (wr_ptr),
        .wr_data (data_in),
        .rd_en   (pop_ok),
        .rd_addr (rd_ptr),
        .rd_data (data_out)
    );

endmodule

// File: tb/tb_fifo_umbral.sv
// Bench for fifo_umbral: hand-written vector table for the threshold/overflow/
// underflow walk, directed corner sequences, then random traffic, all checked
// against a queue-based reference model.
module tb_fifo_umbral;

    localparam int DW    = 6;
    localparam int AW    = 3;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cfg_load = 1'b0;
    logic [7:0]    umbral = 8'h00;
    logic          push = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic          pop = 1'b0;
    logic [DW-1:0] data_out;
    logic          valid_out;
    logic          fifo_full;
    logic          fifo_empty;
    logic          almost_full;
    logic          almost_empty;
    logic          fifo_error;
    logic [AW:0]   count;

    int total = 0;
    int bad   = 0;

    fifo_umbral #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk          (clk),
        .reset        (reset),
        .cfg_load     (cfg_load),
        .umbral       (umbral),
        .push         (push),
        .data_in      (data_in),
        .pop          (pop),
        .data_out     (data_out),
        .valid_out    (valid_out),
        .fifo_full    (fifo_full),
        .fifo_empty   (fifo_empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .fifo_error   (fifo_error),
        .count        (count)
    );

    // Clock.
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [DW-1:0] m_q[$];
    int            m_lo;
    int            m_hi;
    bit            m_err;
    bit            m_valid;
    logic [DW-1:0] m_data;

    task automatic model_reset();
        m_q.delete();
        m_lo = 1; m_hi = DEPTH - 1; m_err = 0; m_valid = 0; m_data = '0;
    endtask

    task automatic model_step(input bit c, input logic [7:0] u, input bit p,
                              input bit q, input logic [DW-1:0] d);
        bit pop_ok;
        bit push_ok;
        pop_ok  = q && (m_q.size() > 0);
        push_ok = p && ((m_q.size() < DEPTH) || pop_ok);
        if ((p && !push_ok) || (q && !pop_ok)) m_err = 1;
        m_valid = pop_ok;
        if (pop_ok) m_data = m_q.pop_front();
        if (push_ok) m_q.push_back(d);
        if (c) begin
            m_lo = int'(u[3:0]);
            m_hi = int'(u[7:4]);
        end
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t act=%0h exp=%0h", nm, $time, act, exp);
        end
    endtask

    task automatic chk_model();
        int hi_eff;
        int n;
        n = m_q.size();
        hi_eff = (m_hi == 0) ? 1 : ((m_hi > DEPTH) ? DEPTH : m_hi);
        chk("m_count", 32'(count), 32'(n));
        chk("m_full", 32'(fifo_full), 32'(n == DEPTH));
        chk("m_empty", 32'(fifo_empty), 32'(n == 0));
        chk("m_almost_full", 32'(almost_full), 32'(n >= hi_eff));
        chk("m_almost_empty", 32'(almost_empty), 32'(n <= m_lo));
        chk("m_error", 32'(fifo_error), 32'(m_err));
        chk("m_valid", 32'(valid_out), 32'(m_valid));
        chk("m_data", 32'(data_out), 32'(m_data));
    endtask

    // ---------------- driver ----------------
    // Called at a negedge; drives, crosses one posedge, checks at the next negedge.
    task automatic step(input bit c, input logic [7:0] u, input bit p,
                        input bit q, input logic [DW-1:0] d);
        cfg_load = c; umbral = u; push = p; pop = q; data_in = d;
        model_step(c, u, p, q, d);
        @(posedge clk);
        @(negedge clk);
        chk_model();
    endtask

    // Async reset asserted mid-cycle while the current inputs stay applied.
    task automatic apply_reset();
        #2 reset = 1'b1;
        #1;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(fifo_empty), 32'd1);
        chk("rst_full", 32'(fifo_full), 32'd0);
        chk("rst_almost_empty", 32'(almost_empty), 32'd1);
        chk("rst_almost_full", 32'(almost_full), 32'd0);
        chk("rst_error", 32'(fifo_error), 32'd0);
        chk("rst_valid", 32'(valid_out), 32'd0);
        chk("rst_data", 32'(data_out), 32'd0);
        @(negedge clk);
        cfg_load = 0; push = 0; pop = 0; data_in = '0; umbral = 8'h00;
        reset = 1'b0;
        model_reset();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit            cfg;
        logic [7:0]    umb;
        bit            push;
        bit            pop;
        logic [DW-1:0] din;
        int            e_cnt;
        bit            e_full;
        bit            e_empty;
        bit            e_af;
        bit            e_ae;
        bit            e_err;
        bit            e_valid;
        logic [DW-1:0] e_data;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit c, logic [7:0] u, bit p, bit q, logic [DW-1:0] d,
                                int cnt, bit fu, bit em, bit af, bit ae, bit er,
                                bit va, logic [DW-1:0] dat);
        vec_t v;
        v.cfg = c; v.umb = u; v.push = p; v.pop = q; v.din = d;
        v.e_cnt = cnt; v.e_full = fu; v.e_empty = em; v.e_af = af; v.e_ae = ae;
        v.e_err = er; v.e_valid = va; v.e_data = dat;
        return v;
    endfunction

    initial begin
        // Thresholds high 6 / low 2, fill 1..8, overflow with 0x3F, drain, underflow.
        tbl.push_back(mk(1, 8'h62, 0, 0, 6'h00, 0, 0, 1, 0, 1, 0, 0, 6'h00));
        tbl.push_back(mk(0, 8'h00, 1, 0, 6'h01, 1, 0, 0, 0, 1, 0, 0, 6'h00));
        tbl.push_back(mk(0, 8'h00, 1, 0, 6'h02, 2, 0, 0, 0, 1, 0, 0, 6'h00));
        tbl.push_back(mk(0, 8'h00, 1, 0, 6'h03, 3, 0, 0, 0, 0, 0, 0, 6'h00));
        tbl.push_back(mk(0, 8'h00, 1, 0, 6'h04, 4, 0, 0, 0, 0, 0, 0, 6'h00));
        tbl.push_back(mk(0, 8'h00, 1, 0, 6'h05, 5, 0, 0, 0, 0, 0, 0, 6'h00));
        tbl.push_back(mk(0, 8'h00, 1, 0, 6'h06, 6, 0, 0, 1, 0, 0, 0, 6'h00));
        tbl.push_back(mk(0, 8'h00, 1, 0, 6'h07, 7, 0, 0, 1, 0, 0, 0, 6'h00));
        tbl.push_back(mk(0, 8'h00, 1, 0, 6'h08, 8, 1, 0, 1, 0, 0, 0, 6'h00));
        tbl.push_back(mk(0, 8'h00, 1, 0, 6'h3F, 8, 1, 0, 1, 0, 1, 0, 6'h00));
        tbl.push_back(mk(0, 8'h00, 0, 1, 6'h00, 7, 0, 0, 1, 0, 1, 1, 6'h01));
        tbl.push_back(mk(0, 8'h00, 0, 1, 6'h00, 6, 0, 0, 1, 0, 1, 1, 6'h02));
        tbl.push_back(mk(0, 8'h00, 0, 1, 6'h00, 5, 0, 0, 0, 0, 1, 1, 6'h03));
        tbl.push_back(mk(0, 8'h00, 0, 1, 6'h00, 4, 0, 0, 0, 0, 1, 1, 6'h04));
        tbl.push_back(mk(0, 8'h00, 0, 1, 6'h00, 3, 0, 0, 0, 0, 1, 1, 6'h05));
        tbl.push_back(mk(0, 8'h00, 0, 1, 6'h00, 2, 0, 0, 0, 1, 1, 1, 6'h06));
        tbl.push_back(mk(0, 8'h00, 0, 1, 6'h00, 1, 0, 0, 0, 1, 1, 1, 6'h07));
        tbl.push_back(mk(0, 8'h00, 0, 1, 6'h00, 0, 0, 1, 0, 1, 1, 1, 6'h08));
        tbl.push_back(mk(0, 8'h00, 0, 1, 6'h00, 0, 0, 1, 0, 1, 1, 0, 6'h08));
        // Error stays set through a new cfg_load and normal traffic.
        tbl.push_back(mk(1, 8'h41, 1, 0, 6'h2A, 1, 0, 0, 0, 1, 1, 0, 6'h08));
        tbl.push_back(mk(0, 8'h00, 0, 1, 6'h00, 0, 0, 1, 0, 1, 1, 1, 6'h2A));

        // Clock/reset: reset held from time 0, released at a negedge.
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk_model();

        foreach (tbl[i]) begin
            step(tbl[i].cfg, tbl[i].umb, tbl[i].push, tbl[i].pop, tbl[i].din);
            chk($sformatf("v%0d_count", i), 32'(count), 32'(tbl[i].e_cnt));
            chk($sformatf("v%0d_full", i), 32'(fifo_full), 32'(tbl[i].e_full));
            chk($sformatf("v%0d_empty", i), 32'(fifo_empty), 32'(tbl[i].e_empty));
            chk($sformatf("v%0d_af", i), 32'(almost_full), 32'(tbl[i].e_af));
            chk($sformatf("v%0d_ae", i), 32'(almost_empty), 32'(tbl[i].e_ae));
            chk($sformatf("v%0d_err", i), 32'(fifo_error), 32'(tbl[i].e_err));
            chk($sformatf("v%0d_valid", i), 32'(valid_out), 32'(tbl[i].e_valid));
            chk($sformatf("v%0d_data", i), 32'(data_out), 32'(tbl[i].e_data));
        end

        // Reset mid-transfer: a push is applied while reset strikes.
        push = 1'b1; data_in = 6'h15;
        apply_reset();
        chk_model();

        // Push and pop together on empty: push accepted, pop rejected, error set.
        step(0, 8'h00, 1, 1, 6'h11);
        chk("empty_pushpop_count", 32'(count), 32'd1);
        chk("empty_pushpop_err", 32'(fifo_error), 32'd1);
        chk("empty_pushpop_valid", 32'(valid_out), 32'd0);

        // Streaming while full: 0x00..0x13 with pointers wrapping.
        apply_reset();
        for (int i = 0; i < DEPTH; i++) step(0, 8'h00, 1, 0, DW'(i));
        for (int i = DEPTH; i < 20; i++) begin
            step(0, 8'h00, 1, 1, DW'(i));
            chk("stream_count", 32'(count), 32'd8);
            chk("stream_data", 32'(data_out), 32'(i - DEPTH));
        end
        for (int i = 0; i < DEPTH; i++) step(0, 8'h00, 0, 1, 6'h00);
        chk("stream_last", 32'(data_out), 32'h13);
        chk("stream_err", 32'(fifo_error), 32'd0);

        // Clamp: high 15 acts as DEPTH; then high 0 acts as 1 with low 0.
        apply_reset();
        step(1, 8'hF0, 0, 0, 6'h00);
        for (int i = 0; i < DEPTH; i++) step(0, 8'h00, 1, 0, DW'(i + 32));
        step(1, 8'h00, 0, 0, 6'h00);
        for (int i = 0; i < DEPTH; i++) step(0, 8'h00, 0, 1, 6'h00);

        // Random traffic with phases biased toward filling and draining.
        apply_reset();
        for (int i = 0; i < 600; i++) begin
            int bias;
            bit c;
            bias = ((i / 50) % 2 == 0) ? 70 : 30;
            c = ($urandom_range(0, 39) == 0);
            step(c, 8'($urandom()), ($urandom_range(0, 99) < bias),
                 ($urandom_range(0, 99) >= bias - 15), DW'($urandom()));
            if (i == 300) apply_reset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_umbral.md
Name: fifo_umbral

Overview:
- Synchronous FIFO with programmable low/high occupancy thresholds (umbrales).
- Supplies the per-FIFO status bits (fifo_empty, fifo_error) that the control FSM consumes on its FIFO_EMPTY/FIFO_ERROR buses.
- Takes the packed 8-bit threshold word the FSM drives (UMF/UVC/UD_OUT); one instance per FIFO in the datapath.
- Almost-full/almost-empty outputs provide upstream pause and downstream flow control.

Parameters:
- DATA_WIDTH, 6, payload width in bits.
- ADDR_WIDTH, 3, pointer width; DEPTH = 2**ADDR_WIDTH (8 entries; max 16 because thresholds are 4-bit).
- UMBRAL_BAJO_RST, 1, low threshold after reset.
- UMBRAL_ALTO_RST, DEPTH-1, high threshold after reset.

Ports:
- clk  in  1  single clock, all logic on posedge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- cfg_load  in  1  capture umbral this cycle (asserted by the FSM in INIT).
- umbral  in  8  [3:0] low threshold, [7:4] high threshold.
- push  in  1  write request.
- data_in  in  DATA_WIDTH  write data.
- pop  in  1  read request.
- data_out  out  DATA_WIDTH  registered read data.
- valid_out  out  1  data_out valid, one pulse per accepted pop.
- fifo_full  out  1  count == DEPTH.
- fifo_empty  out  1  count == 0.
- almost_full  out  1  count >= high threshold.
- almost_empty  out  1  count <= low threshold.
- fifo_error  out  1  sticky overflow/underflow flag.
- count  out  ADDR_WIDTH+1  current occupancy.

Behaviour:
- Reset (async, high):
  - wr_ptr = rd_ptr = count = 0; data_out = 0; valid_out = 0; fifo_error = 0.
  - fifo_empty = 1, fifo_full = 0, almost_empty = 1, almost_full = 0.
  - Thresholds return to *_RST values; memory contents are don't-care.
- Threshold capture:
  - On posedge with cfg_load=1, the low/high registers take umbral[3:0] and umbral[7:4].
  - New thresholds affect the flags from the next cycle.
  - A high threshold > DEPTH is clamped to DEPTH; a high threshold of 0 is treated as 1.
- Push:
  - Accepted if !fifo_full, or if fifo_full and an accepted pop occurs in the same cycle.
  - An accepted push writes mem[wr_ptr] and increments wr_ptr, which wraps modulo DEPTH.
  - A rejected push drops the data and sets fifo_error.
- Pop:
  - Accepted if !fifo_empty.
  - data_out <= mem[rd_ptr] and valid_out = 1 on the next edge (latency 1); rd_ptr increments and wraps.
  - A pop on empty is rejected, valid_out stays 0 and fifo_error is set, even if a push occurs the same cycle (no fall-through).
  - data_out holds its last value when no pop is accepted.
- Count update: +1 for push only, -1 for pop only, unchanged when both are accepted.
- Flags are combinational from registered count and thresholds, so they update on the cycle after the edge that changed count.
- fifo_error is sticky:
  - Cleared only by reset, not by cfg_load. This matches the FSM's ERROR state, whose only exit is reset.
- A reset asserted mid-transfer aborts the transfer; no partial write is retained.

Decomposition:
- Shared package fifo_pkg:
  - DATA_WIDTH and ADDR_WIDTH defaults.
  - Threshold field positions (BAJO_LSB=0, ALTO_LSB=4, field width 4).
  - Reset threshold constants.
- One sub-module, fifo_mem:
  - DEPTH x DATA_WIDTH register file.
  - One synchronous write port and one registered read port.
- Pointer, count, flag and error logic stay in fifo_umbral.

Test Plan:
- Reset then idle: assert reset mid-cycle (async) -> all outputs take their reset values immediately; fifo_empty=1, almost_empty=1, count=0.
- Threshold program and fill: cfg_load with umbral=8'h62 (high 6, low 2), push 0x01..0x08 -> almost_empty drops at count=3, almost_full rises at count=6, fifo_full at count=8.
- Overflow: push a 9th word 0x3F while full, no pop -> fifo_error=1 and stays 1; count stays 8; draining 8 pops returns 0x01..0x08 in order with valid_out pulses and no 0x3F.
- Underflow and stickiness: pop on empty -> valid_out=0, fifo_error=1; then cfg_load and normal traffic -> fifo_error remains 1 until reset.
- Simultaneous push and pop:
  - When full: count stays 8, no error, wr_ptr/rd_ptr wrap correctly over 20 cycles of streaming 0x00..0x13, and output order is preserved.
  - When empty: push accepted, pop rejected, error set.
- Clamp: cfg_load umbral=8'hF0 with DEPTH=8 -> almost_full asserts only at count=8; umbral=8'h00 -> almost_full at count>=1, almost_empty only at count=0.
